// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: two write ports, two registered read ports,
// the clear request and the busy flag.
interface reg_file_mp_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic             we1;
  logic [AW-1:0]    wa1;
  logic [WIDTH-1:0] wd1;
  logic             we2;
  logic [AW-1:0]    wa2;
  logic [WIDTH-1:0] wd2;
  logic             re1;
  logic [AW-1:0]    ra1;
  logic [WIDTH-1:0] rd1;
  logic             rv1;
  logic             re2;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd2;
  logic             rv2;
  logic             clr;
  logic             busy;

  modport master (
    output we1, wa1, wd1, we2, wa2, wd2, re1, ra1, re2, ra2, clr,
    input  rd1, rv1, rd2, rv2, busy
  );

  modport slave (
    input  we1, wa1, wd1, we2, wa2, wd2, re1, ra1, re2, ra2, clr,
    output rd1, rv1, rd2, rv2, busy
  );
endinterface

// File: rtl/reg_file_mp.sv
// Two-write / two-read register file with port-1 write priority, optional
// write-to-read forwarding and a zeroing sweep after reset or clear.
//
// state | meaning
// INIT  | sweep writes 0 to one entry per edge; all accesses ignored
// IDLE  | normal reads/writes; clr restarts the sweep
module reg_file_mp #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_mp_if.slave  rf_if
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {INIT = 1'b0, IDLE = 1'b1} state_t;

  state_t           state_q;
  logic [AW-1:0]    cnt_q;
  logic [WIDTH-1:0] rd1_q, rd2_q;
  logic             rv1_q, rv2_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             w1_ok, w2_ok;
  logic             ra1_ok, ra2_ok;
  logic [WIDTH-1:0] rd1_d, rd2_d;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  always_comb begin
    w1_ok  = rf_if.we1 && in_range(rf_if.wa1);
    // port 1 wins a same-address collision, so port 2 is simply suppressed
    w2_ok  = rf_if.we2 && in_range(rf_if.wa2) && !(w1_ok && rf_if.wa2 == rf_if.wa1);
    ra1_ok = in_range(rf_if.ra1);
    ra2_ok = in_range(rf_if.ra2);

    rd1_d = '0;
    if (ra1_ok) begin
      if (BYPASS && w1_ok && rf_if.wa1 == rf_if.ra1)      rd1_d = rf_if.wd1;
      else if (BYPASS && w2_ok && rf_if.wa2 == rf_if.ra1) rd1_d = rf_if.wd2;
      else                                                 rd1_d = mem_q[rf_if.ra1];
    end

    rd2_d = '0;
    if (ra2_ok) begin
      if (BYPASS && w1_ok && rf_if.wa1 == rf_if.ra2)      rd2_d = rf_if.wd1;
      else if (BYPASS && w2_ok && rf_if.wa2 == rf_if.ra2) rd2_d = rf_if.wd2;
      else                                                 rd2_d = mem_q[rf_if.ra2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rv1_q   <= 1'b0;
      rv2_q   <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          rv1_q <= 1'b0;
          rv2_q <= 1'b0;
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (rf_if.clr) begin
            state_q <= INIT;
            cnt_q   <= '0;
            rv1_q   <= 1'b0;
            rv2_q   <= 1'b0;
            rd1_q   <= '0;
            rd2_q   <= '0;
          end else begin
            rv1_q <= rf_if.re1;
            rv2_q <= rf_if.re2;
            if (rf_if.re1) rd1_q <= rd1_d;
            if (rf_if.re2) rd2_q <= rd2_d;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Storage carries no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (!rf_if.clr) begin
      if (w1_ok) mem_q[rf_if.wa1] <= rf_if.wd1;
      if (w2_ok) mem_q[rf_if.wa2] <= rf_if.wd2;
    end
  end

  assign rf_if.rd1  = rd1_q;
  assign rf_if.rd2  = rd2_q;
  assign rf_if.rv1  = rv1_q;
  assign rf_if.rv2  = rv2_q;
  assign rf_if.busy = (state_q == INIT);
endmodule
